// File: rtl/piece_move_ctrl.sv
// Falling-piece position sequencer: merges gravity with drop/left/right requests,
// clears each move through the board collision checker, then locks/spawns/game-over.
module piece_move_ctrl #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 20,
  parameter int SPAWN_X    = 5,
  parameter int GRAV_TICKS = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_drop,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_chk_ack,
  input  logic       i_chk_hit,
  input  logic       i_lock_done,
  output logic [4:0] o_pos_x,
  output logic [4:0] o_pos_y,
  output logic       o_chk_req,
  output logic [4:0] o_chk_x,
  output logic [4:0] o_chk_y,
  output logic       o_lock_req,
  output logic       o_busy,
  output logic       o_game_over
);
  localparam int            CW      = $clog2(GRAV_TICKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(GRAV_TICKS - 1);
  localparam logic [4:0]    SX      = 5'(SPAWN_X);
  localparam logic [4:0]    XMAX    = 5'(BOARD_W - 1);
  localparam logic [4:0]    YMAX    = 5'(BOARD_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_SPAWN_CHK, S_READY, S_CHECK, S_LOCK, S_OVER
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_grav_pend, r_drop_pend, r_left_pend, r_right_pend;
  logic          r_is_down;
  logic [4:0]    r_pos_x, r_pos_y, r_chk_x, r_chk_y;
  logic          r_chk_req, r_lock_req, r_game_over;

  logic w_run, w_wrap, w_down;
  assign w_run  = (r_state == S_SPAWN_CHK) || (r_state == S_READY) || (r_state == S_CHECK);
  assign w_wrap = w_run && (r_cnt == CNT_MAX);
  assign w_down = r_grav_pend | r_drop_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_grav_pend  <= 1'b0;
      r_drop_pend  <= 1'b0;
      r_left_pend  <= 1'b0;
      r_right_pend <= 1'b0;
      r_is_down    <= 1'b0;
      r_pos_x      <= SX;
      r_pos_y      <= 5'd0;
      r_chk_req    <= 1'b0;
      r_chk_x      <= 5'd0;
      r_chk_y      <= 5'd0;
      r_lock_req   <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      if (w_run) r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      case (r_state)
        S_IDLE, S_OVER: begin
          r_cnt        <= '0;
          r_grav_pend  <= 1'b0;
          r_drop_pend  <= 1'b0;
          r_left_pend  <= 1'b0;
          r_right_pend <= 1'b0;
          if (i_start) begin
            r_state     <= S_SPAWN;
            r_pos_x     <= SX;
            r_pos_y     <= 5'd0;
            r_game_over <= 1'b0;
          end
        end
        S_SPAWN: begin
          r_pos_x      <= SX;
          r_pos_y      <= 5'd0;
          r_cnt        <= '0;
          r_grav_pend  <= 1'b0;
          r_drop_pend  <= 1'b0;
          r_left_pend  <= 1'b0;
          r_right_pend <= 1'b0;
          r_chk_req    <= 1'b1;
          r_chk_x      <= SX;
          r_chk_y      <= 5'd0;
          r_is_down    <= 1'b0;
          r_state      <= S_SPAWN_CHK;
        end
        S_SPAWN_CHK: if (i_chk_ack) begin
          r_chk_req <= 1'b0;
          if (i_chk_hit) begin
            r_state     <= S_OVER;
            r_game_over <= 1'b1;
          end else r_state <= S_READY;
        end
        S_READY: begin
          // gravity and soft drop share the down slot; a reject still consumes the flag
          if (w_down) begin
            r_grav_pend <= 1'b0;
            r_drop_pend <= 1'b0;
            if (r_pos_y == YMAX) begin
              r_state    <= S_LOCK;
              r_lock_req <= 1'b1;
            end else begin
              r_chk_req <= 1'b1;
              r_chk_x   <= r_pos_x;
              r_chk_y   <= r_pos_y + 5'd1;
              r_is_down <= 1'b1;
              r_state   <= S_CHECK;
            end
          end else if (r_left_pend) begin
            r_left_pend <= 1'b0;
            if (r_pos_x != 5'd0) begin
              r_chk_req <= 1'b1;
              r_chk_x   <= r_pos_x - 5'd1;
              r_chk_y   <= r_pos_y;
              r_is_down <= 1'b0;
              r_state   <= S_CHECK;
            end
          end else if (r_right_pend) begin
            r_right_pend <= 1'b0;
            if (r_pos_x != XMAX) begin
              r_chk_req <= 1'b1;
              r_chk_x   <= r_pos_x + 5'd1;
              r_chk_y   <= r_pos_y;
              r_is_down <= 1'b0;
              r_state   <= S_CHECK;
            end
          end
        end
        S_CHECK: if (i_chk_ack) begin
          r_chk_req <= 1'b0;
          if (!i_chk_hit) begin
            r_pos_x <= r_chk_x;
            r_pos_y <= r_chk_y;
            r_state <= S_READY;
          end else if (r_is_down) begin
            r_state    <= S_LOCK;
            r_lock_req <= 1'b1;
          end else r_state <= S_READY;
        end
        S_LOCK: if (i_lock_done) begin
          r_lock_req <= 1'b0;
          r_pos_x    <= SX;
          r_pos_y    <= 5'd0;
          r_state    <= S_SPAWN;
        end
        default: r_state <= S_IDLE;
      endcase
      // request capture comes last so a still-held input re-arms a flag being serviced
      if (w_run) begin
        if (i_drop)  r_drop_pend  <= 1'b1;
        if (i_left)  r_left_pend  <= 1'b1;
        if (i_right) r_right_pend <= 1'b1;
        if (w_wrap)  r_grav_pend  <= 1'b1;
      end
    end
  end

  assign o_pos_x     = r_pos_x;
  assign o_pos_y     = r_pos_y;
  assign o_chk_req   = r_chk_req;
  assign o_chk_x     = r_chk_x;
  assign o_chk_y     = r_chk_y;
  assign o_lock_req  = r_lock_req;
  assign o_game_over = r_game_over;
  assign o_busy      = !((r_state == S_IDLE) || (r_state == S_READY) || (r_state == S_OVER));
endmodule

// File: tb/tb_piece_move_ctrl.sv
// Bench for piece_move_ctrl: board-model checker responder, directed scenarios and
// randomized single moves compared against a cell-level position model.
module tb_piece_move_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, drop = 1'b0, left = 1'b0, right = 1'b0;
  logic chk_ack = 1'b0, chk_hit = 1'b0, lock_done = 1'b0;
  logic [4:0] pos_x, pos_y, chk_x, chk_y;
  logic chk_req, lock_req, busy, game_over;

  logic g_rst = 1'b1, g_start = 1'b0, g_idle_in = 1'b0;
  logic g_chk_ack = 1'b0, g_chk_hit = 1'b0;
  logic [4:0] g_pos_x, g_pos_y, g_chk_x, g_chk_y;
  logic g_chk_req, g_lock_req, g_busy, g_game_over;

  piece_move_ctrl #(.BOARD_W(10), .BOARD_H(20), .SPAWN_X(5), .GRAV_TICKS(100000)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_drop(drop), .i_left(left), .i_right(right),
    .i_chk_ack(chk_ack), .i_chk_hit(chk_hit), .i_lock_done(lock_done),
    .o_pos_x(pos_x), .o_pos_y(pos_y), .o_chk_req(chk_req), .o_chk_x(chk_x), .o_chk_y(chk_y),
    .o_lock_req(lock_req), .o_busy(busy), .o_game_over(game_over));

  piece_move_ctrl #(.BOARD_W(10), .BOARD_H(20), .SPAWN_X(5), .GRAV_TICKS(4)) dut_g (
    .i_clk(clk), .i_rst(g_rst), .i_start(g_start), .i_drop(g_idle_in), .i_left(g_idle_in),
    .i_right(g_idle_in), .i_chk_ack(g_chk_ack), .i_chk_hit(g_chk_hit), .i_lock_done(g_idle_in),
    .o_pos_x(g_pos_x), .o_pos_y(g_pos_y), .o_chk_req(g_chk_req), .o_chk_x(g_chk_x),
    .o_chk_y(g_chk_y), .o_lock_req(g_lock_req), .o_busy(g_busy), .o_game_over(g_game_over));

  int total = 0, bad = 0;
  bit occ [10][20];
  int lat = 1, rw = 0, gw = 0;
  bit inhibit = 1'b0;

  // checker model for the main instance: acks after `lat` cycles, hit from the board array
  initial forever begin
    @(negedge clk);
    if (!inhibit) begin
      chk_ack = 1'b0;
      chk_hit = 1'b0;
      if (chk_req) begin
        rw++;
        if (rw >= lat) begin
          chk_ack = 1'b1;
          chk_hit = (chk_x < 10 && chk_y < 20) ? occ[chk_x][chk_y] : 1'b1;
          rw = 0;
        end
      end else rw = 0;
    end
  end

  // empty board, fixed 3-cycle latency for the gravity instance
  initial forever begin
    @(negedge clk);
    g_chk_ack = 1'b0;
    if (g_chk_req) begin
      gw++;
      if (gw >= 3) begin g_chk_ack = 1'b1; gw = 0; end
    end else gw = 0;
  end

  task automatic pulse(input int kind);
    @(negedge clk);
    case (kind)
      0: drop = 1'b1;
      1: left = 1'b1;
      2: right = 1'b1;
      default: start = 1'b1;
    endcase
    @(negedge clk);
    drop = 1'b0; left = 1'b0; right = 1'b0; start = 1'b0;
  endtask

  task automatic settle(output bit locked);
    bit done = 1'b0;
    locked = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (lock_req) begin
        lock_done = 1'b1;
        @(negedge clk);
        lock_done = 1'b0;
        locked = 1'b1;
      end else if (!busy) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL settle: still busy at pos=(%0d,%0d), required idle within 100 cycles", pos_x, pos_y);
    end
  endtask

  task automatic do_move(input int kind, output bit locked);
    pulse(kind);
    settle(locked);
  endtask

  task automatic restart();
    bit lk;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pulse(3);
    settle(lk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (pos_x !== 5'd5 || pos_y !== 5'd0 || chk_req !== 1'b0 || chk_x !== 5'd0 || chk_y !== 5'd0 ||
        lock_req !== 1'b0 || busy !== 1'b0 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL reset: pos=(%0d,%0d) chk_req=%b chk=(%0d,%0d) lock_req=%b busy=%b go=%b, required (5,0) 0 (0,0) 0 0 0",
               pos_x, pos_y, chk_req, chk_x, chk_y, lock_req, busy, game_over);
    end
    rst = 1'b0;
  endtask

  task automatic test_spawn();
    lat = 1;
    pulse(3);
    total++;
    if (busy !== 1'b1 || chk_req !== 1'b0) begin
      bad++; $display("FAIL spawn_state: busy=%b chk_req=%b, required 1 0", busy, chk_req);
    end
    @(negedge clk);
    total++;
    if (chk_req !== 1'b1 || chk_x !== 5'd5 || chk_y !== 5'd0) begin
      bad++; $display("FAIL spawn_query: req=%b chk=(%0d,%0d), required 1 (5,0)", chk_req, chk_x, chk_y);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || pos_x !== 5'd5 || pos_y !== 5'd0 || game_over !== 1'b0 || chk_req !== 1'b0) begin
      bad++; $display("FAIL spawn_ready: busy=%b pos=(%0d,%0d) go=%b req=%b, required 0 (5,0) 0 0",
                      busy, pos_x, pos_y, game_over, chk_req);
    end
  endtask

  task automatic test_left_wall();
    bit lk, seen = 1'b0;
    for (int i = 0; i < 5; i++) do_move(1, lk);
    for (int i = 0; i < 7; i++) do_move(0, lk);
    total++;
    if (pos_x !== 5'd0 || pos_y !== 5'd7) begin
      bad++; $display("FAIL walk_to_0_7: pos=(%0d,%0d), required (0,7)", pos_x, pos_y);
    end
    pulse(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (chk_req) seen = 1'b1;
    end
    total++;
    if (seen || pos_x !== 5'd0 || pos_y !== 5'd7) begin
      bad++; $display("FAIL left_wall: query_seen=%b pos=(%0d,%0d), required 0 (0,7)", seen, pos_x, pos_y);
    end
    do_move(2, lk);
    total++;
    if (pos_x !== 5'd1 || pos_y !== 5'd7) begin
      bad++; $display("FAIL left_flag_cleared: pos=(%0d,%0d), required (1,7)", pos_x, pos_y);
    end
  endtask

  task automatic test_priority();
    bit lk, dropped = 1'b0, got = 1'b0;
    restart();
    do_move(1, lk);
    for (int i = 0; i < 3; i++) do_move(0, lk);
    lat = 2;
    @(negedge clk); left = 1'b1; drop = 1'b1;
    @(negedge clk); left = 1'b0; drop = 1'b0;
    @(negedge clk);
    total++;
    if (chk_req !== 1'b1 || chk_x !== 5'd4 || chk_y !== 5'd4) begin
      bad++; $display("FAIL prio_first: req=%b chk=(%0d,%0d), required 1 (4,4)", chk_req, chk_x, chk_y);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!chk_req) dropped = 1'b1;
      else if (dropped) begin got = 1'b1; break; end
    end
    total++;
    if (!got || chk_x !== 5'd3 || chk_y !== 5'd4 || pos_x !== 5'd4 || pos_y !== 5'd4) begin
      bad++; $display("FAIL prio_second: got=%b chk=(%0d,%0d) pos=(%0d,%0d), required 1 (3,4) (4,4)",
                      got, chk_x, chk_y, pos_x, pos_y);
    end
    settle(lk);
    total++;
    if (pos_x !== 5'd3 || pos_y !== 5'd4) begin
      bad++; $display("FAIL prio_final: pos=(%0d,%0d), required (3,4)", pos_x, pos_y);
    end
  endtask

  task automatic test_lock();
    bit lk, seen = 1'b0;
    lat = 1;
    do_move(2, lk);
    for (int i = 0; i < 14; i++) do_move(0, lk);
    occ[4][19] = 1'b1;
    pulse(0);
    @(negedge clk);
    total++;
    if (chk_req !== 1'b1 || chk_x !== 5'd4 || chk_y !== 5'd19) begin
      bad++; $display("FAIL lock_query: req=%b chk=(%0d,%0d), required 1 (4,19)", chk_req, chk_x, chk_y);
    end
    repeat (2) @(negedge clk);
    total++;
    if (lock_req !== 1'b1 || busy !== 1'b1 || pos_x !== 5'd4 || pos_y !== 5'd18) begin
      bad++; $display("FAIL lock_hold: lock_req=%b busy=%b pos=(%0d,%0d), required 1 1 (4,18)",
                      lock_req, busy, pos_x, pos_y);
    end
    lock_done = 1'b1;
    @(negedge clk);
    lock_done = 1'b0;
    total++;
    if (lock_req !== 1'b0 || busy !== 1'b1 || pos_x !== 5'd5 || pos_y !== 5'd0) begin
      bad++; $display("FAIL lock_spawn: lock_req=%b busy=%b pos=(%0d,%0d), required 0 1 (5,0)",
                      lock_req, busy, pos_x, pos_y);
    end
    occ[4][19] = 1'b0;
    settle(lk);
    for (int i = 0; i < 19; i++) do_move(0, lk);
    total++;
    if (pos_x !== 5'd5 || pos_y !== 5'd19) begin
      bad++; $display("FAIL walk_bottom: pos=(%0d,%0d), required (5,19)", pos_x, pos_y);
    end
    pulse(0);
    @(negedge clk);
    if (chk_req) seen = 1'b1;
    total++;
    if (lock_req !== 1'b1 || seen) begin
      bad++; $display("FAIL bottom_lock: lock_req=%b query=%b, required 1 0", lock_req, seen);
    end
    settle(lk);
  endtask

  task automatic test_over();
    bit lk;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    occ[5][0] = 1'b1;
    pulse(3);
    settle(lk);
    total++;
    if (game_over !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL over_enter: go=%b busy=%b, required 1 0", game_over, busy);
    end
    occ[5][0] = 1'b0;
    pulse(3);
    total++;
    if (game_over !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL over_restart: go=%b busy=%b, required 0 1", game_over, busy);
    end
    settle(lk);
    total++;
    if (game_over !== 1'b0 || pos_x !== 5'd5 || pos_y !== 5'd0) begin
      bad++; $display("FAIL over_ready: go=%b pos=(%0d,%0d), required 0 (5,0)", game_over, pos_x, pos_y);
    end
  endtask

  task automatic test_gravity();
    int prev, steps = 0, falls = 0, bad_step = 0;
    logic prev_req = 1'b0;
    @(negedge clk); g_rst = 1'b0; g_start = 1'b1;
    @(negedge clk); g_start = 1'b0;
    prev = int'(g_pos_y);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (int'(g_pos_y) != prev) begin
        if (int'(g_pos_y) != prev + 1) bad_step++;
        steps++;
        prev = int'(g_pos_y);
      end
      if (prev_req && !g_chk_req) falls++;
      prev_req = g_chk_req;
    end
    total++;
    if (bad_step != 0 || steps < 8 || g_pos_x !== 5'd5 || g_lock_req !== 1'b0) begin
      bad++; $display("FAIL gravity_steps: steps=%0d bad_steps=%0d x=%0d lock=%b, required >=8 0 5 0",
                      steps, bad_step, g_pos_x, g_lock_req);
    end
    total++;
    if (steps != falls - 1 && steps != falls) begin
      bad++; $display("FAIL gravity_overlap: completed_queries=%0d moves=%0d, required one query per move", falls, steps);
    end
  endtask

  task automatic test_rst_mid();
    bit lk;
    inhibit = 1'b1;
    chk_ack = 1'b0;
    pulse(0);
    @(negedge clk);
    total++;
    if (chk_req !== 1'b1 || chk_x !== 5'd5 || chk_y !== 5'd1) begin
      bad++; $display("FAIL rstmid_query: req=%b chk=(%0d,%0d), required 1 (5,1)", chk_req, chk_x, chk_y);
    end
    rst = 1'b1; chk_ack = 1'b1; chk_hit = 1'b0;
    @(negedge clk);
    rst = 1'b0; chk_ack = 1'b0;
    total++;
    if (busy !== 1'b0 || chk_req !== 1'b0 || pos_x !== 5'd5 || pos_y !== 5'd0) begin
      bad++; $display("FAIL rstmid_abort: busy=%b req=%b pos=(%0d,%0d), required 0 0 (5,0)", busy, chk_req, pos_x, pos_y);
    end
    chk_ack = 1'b1;
    @(negedge clk);
    chk_ack = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || chk_req !== 1'b0 || pos_x !== 5'd5 || pos_y !== 5'd0) begin
      bad++; $display("FAIL stale_ack: busy=%b req=%b pos=(%0d,%0d), required 0 0 (5,0)", busy, chk_req, pos_x, pos_y);
    end
    inhibit = 1'b0;
    pulse(3);
    settle(lk);
    occ[5][1] = 1'b1;
    pulse(0);
    repeat (3) @(negedge clk);
    rst = 1'b1; lock_done = 1'b1;
    @(negedge clk);
    rst = 1'b0; lock_done = 1'b0;
    total++;
    if (busy !== 1'b0 || lock_req !== 1'b0 || pos_y !== 5'd0) begin
      bad++; $display("FAIL rst_lock: busy=%b lock_req=%b y=%0d, required 0 0 0", busy, lock_req, pos_y);
    end
    occ[5][1] = 1'b0;
  endtask

  task automatic test_random();
    int mx = 5, my = 0, k;
    bit elock, lk;
    for (int x = 0; x < 10; x++) for (int y = 0; y < 20; y++) occ[x][y] = 1'b0;
    for (int i = 0; i < 15; i++) occ[$urandom_range(0, 9)][$urandom_range(1, 19)] = 1'b1;
    restart();
    for (int it = 0; it < 40; it++) begin
      k = int'($urandom_range(0, 2));
      lat = int'($urandom_range(1, 4));
      elock = 1'b0;
      case (k)
        0: if (my == 19 || occ[mx][my+1]) elock = 1'b1; else my++;
        1: if (mx > 0 && !occ[mx-1][my]) mx--;
        default: if (mx < 9 && !occ[mx+1][my]) mx++;
      endcase
      if (elock) begin mx = 5; my = 0; end
      do_move(k, lk);
      total++;
      if (lk !== elock || pos_x !== mx[4:0] || pos_y !== my[4:0]) begin
        bad++; $display("FAIL random_move[%0d] kind=%0d: lock=%b pos=(%0d,%0d), required lock=%b (%0d,%0d)",
                        it, k, lk, pos_x, pos_y, elock, mx, my);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_left_wall();
    test_priority();
    test_lock();
    test_over();
    test_gravity();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
